// File: rtl/logicnet_input_stage.sv
// logicnet_input_stage: quantizes a stream of signed readout samples and packs
// NUM_FEAT of them into one registered, handshaked feature vector for the
// layer-0 neuron LUTs. The next vector is collected while the current one is
// held and drained, so the stage sustains one sample per cycle.
module logicnet_input_stage #(
    parameter int IN_W     = 16,
    parameter int NUM_FEAT = 2,
    parameter int QBITS    = 3,
    parameter int SHIFT    = 8,
    parameter int OFFSET   = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [IN_W-1:0]    s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [NUM_FEAT*QBITS-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      err_frame
);

    localparam int IW = (NUM_FEAT > 2) ? $clog2(NUM_FEAT) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_FEAT - 1);
    localparam logic signed [IN_W+1:0] OFF_EXT = (IN_W + 2)'(OFFSET);
    localparam logic signed [IN_W+1:0] QMAX    = (IN_W + 2)'((1 << QBITS) - 1);

    // Offset, arithmetic shift and clamp into [0, 2^QBITS-1]. Two guard bits
    // keep the offset add from overflowing for any sample value.
    function automatic logic [QBITS-1:0] quantize(input logic signed [IN_W-1:0] d);
        logic signed [IN_W+1:0] y;
        logic signed [IN_W+1:0] z;
        y = $signed({{2{d[IN_W-1]}}, d}) + OFF_EXT;
        z = y >>> SHIFT;
        if (z[IN_W+1])
            quantize = '0;
        else if (z > QMAX)
            quantize = '1;
        else
            quantize = z[QBITS-1:0];
    endfunction

    logic [IW-1:0]                     idx;
    logic [(NUM_FEAT-1)*QBITS-1:0]     coll;
    logic [QBITS-1:0]                  q;
    logic                              acc;
    logic                              is_final;

    assign q        = quantize(s_data);
    assign is_final = (idx == LAST);
    // Only the final slot can stall: it needs room in the output register.
    assign s_ready  = !rst && (!is_final || !m_valid || m_ready);
    assign acc      = s_valid && s_ready;

    // Index counter, framing check and output-valid tracking (load beats drain).
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            m_valid   <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            if (m_valid && m_ready)
                m_valid <= 1'b0;
            if (acc) begin
                if (is_final) begin
                    idx     <= '0;
                    m_valid <= 1'b1;
                end else if (s_last) begin
                    idx       <= '0;
                    err_frame <= 1'b1;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

    // Collection buffer and output register; the final feature bypasses the
    // buffer straight into the MSB slot of the output vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll   <= '0;
            m_data <= '0;
        end else if (acc) begin
            if (is_final)
                m_data <= {q, coll};
            else if (!s_last)
                coll[idx*QBITS +: QBITS] <= q;
        end
    end

endmodule

// File: tb/tb_logicnet_input_stage.sv
module tb_logicnet_input_stage;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               s_last;
    logic               s_ready;
    logic [5:0]         m_data;
    logic               m_valid;
    logic               m_ready;
    logic               err_frame;

    int tests = 0;
    int fails = 0;

    logicnet_input_stage #(
        .IN_W(16), .NUM_FEAT(2), .QBITS(3), .SHIFT(8), .OFFSET(1024)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] s0;
        logic signed [15:0] s1;
        logic [5:0]         exp;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference quantizer written with floor division rather than shifts.
    function automatic logic [2:0] ref_q(input int d);
        int y;
        int z;
        y = d + 1024;
        if (y >= 0) z = y / 256;
        else        z = -((-y + 255) / 256);
        if (z < 0)      return 3'd0;
        else if (z > 7) return 3'd7;
        else            return z[2:0];
    endfunction

    // Called at a negedge (+ small offset); returns at the negedge after the accept.
    task automatic send(input logic signed [15:0] d, input logic l);
        int n;
        n = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        #1;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: s_ready stuck at 0, expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
    endtask

    logic [5:0] expq[$];
    logic [2:0] prev_q;
    int         k;
    int         got;
    int         cyc;
    logic signed [15:0] smp[100];

    initial begin
        tbl[0] = '{16'sd0,     16'sd2048,   6'b111_100};
        tbl[1] = '{-16'sd2048, -16'sd1,     6'b011_000};
        tbl[2] = '{16'sd32767, -16'sd32768, 6'b000_111};
        tbl[3] = '{16'sd1023,  16'sd767,    6'b110_111};
        tbl[4] = '{-16'sd768,  -16'sd1025,  6'b000_001};
        tbl[5] = '{16'sd1024,  -16'sd1024,  6'b000_111};
        tbl[6] = '{16'sd255,   16'sd512,    6'b110_100};

        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        @(negedge clk); #1;
        check("reset_s_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_m_valid", {31'd0, m_valid}, 32'd0);
        check("reset_m_data", {26'd0, m_data}, 32'd0);
        check("reset_err", {31'd0, err_frame}, 32'd0);
        check("reset_s_ready_after", {31'd0, s_ready}, 32'd1);

        // Table-driven vectors with the consumer always ready.
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].s0, 1'b0);
            check($sformatf("tbl%0d_mid_valid", i), {31'd0, m_valid}, 32'd0);
            send(tbl[i].s1, 1'b1);
            check($sformatf("tbl%0d_valid", i), {31'd0, m_valid}, 32'd1);
            check($sformatf("tbl%0d_data", i), {26'd0, m_data}, {26'd0, tbl[i].exp});
        end
        @(negedge clk); #1;
        check("drain_valid", {31'd0, m_valid}, 32'd0);

        // Backpressure: one vector held, the next stalls at its final sample.
        m_ready = 1'b0;
        send(16'sd0, 1'b0);
        send(16'sd2048, 1'b1);
        send(-16'sd2048, 1'b0);
        check("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
        s_data = -16'sd1; s_last = 1'b1; s_valid = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        check("bp_hold_valid", {31'd0, m_valid}, 32'd1);
        check("bp_hold_data", {26'd0, m_data}, 32'b111_100);
        check("bp_still_stalled", {31'd0, s_ready}, 32'd0);
        m_ready = 1'b1;
        #1;
        check("bp_ready_comb", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        #1;
        check("bp_reload_valid", {31'd0, m_valid}, 32'd1);
        check("bp_reload_data", {26'd0, m_data}, 32'b011_000);
        m_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_drained", {31'd0, m_valid}, 32'd0);

        // Misframe: s_last on the first sample discards it.
        send(16'sd100, 1'b1);
        check("mf_err_pulse", {31'd0, err_frame}, 32'd1);
        check("mf_no_valid", {31'd0, m_valid}, 32'd0);
        @(negedge clk); #1;
        check("mf_err_single", {31'd0, err_frame}, 32'd0);
        send(16'sd0, 1'b0);
        send(16'sd0, 1'b1);
        check("mf_next_valid", {31'd0, m_valid}, 32'd1);
        check("mf_next_data", {26'd0, m_data}, 32'b100_100);
        check("mf_no_err", {31'd0, err_frame}, 32'd0);
        @(negedge clk); #1;

        // Reset with a held vector and a partial one in flight.
        m_ready = 1'b0;
        send(16'sd0, 1'b0);
        send(16'sd2048, 1'b1);
        send(16'sd0, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_cycle_s_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {26'd0, m_data}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        m_ready = 1'b1;
        send(16'sd2048, 1'b0);
        send(16'sd0, 1'b1);
        check("rst_fresh_data", {26'd0, m_data}, 32'b100_111);
        check("rst_fresh_valid", {31'd0, m_valid}, 32'd1);

        // Streaming with random backpressure and a scoreboard.
        for (int i = 0; i < 100; i++) begin
            if (i % 3 == 0) smp[i] = 16'($urandom_range(0, 65535));
            else            smp[i] = 16'(int'($urandom_range(0, 4000)) - 1500);
        end
        k = 0; got = 0; cyc = 0; prev_q = '0;
        @(negedge clk);
        while (cyc < 3000 && (k < 100 || expq.size() != 0 || m_valid)) begin
            m_ready = (k >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
            if (k < 100) begin
                s_valid = ($urandom_range(0, 7) != 0);
                s_data  = smp[k];
                s_last  = (k % 2 == 1);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            #1;
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL stream_extra: got %0h, expected no vector", m_data);
                end else begin
                    check($sformatf("stream_vec%0d", got), {26'd0, m_data}, {26'd0, expq.pop_front()});
                end
                got++;
            end
            if (s_valid && s_ready) begin
                if (k % 2 == 1) expq.push_back({ref_q(int'(smp[k])), prev_q});
                else            prev_q = ref_q(int'(smp[k]));
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        check("stream_count", got, 32'd50);
        check("stream_leftover", expq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
